dcache_2way: RTL and testbench



---
 rtl/dcache_2way.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dcache_2way.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way.sv
// Two-way set-associative, write-back, write-allocate L1 data cache.
// 256 sets x 2 ways x 16-byte lines; one LRU bit per set.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   addr, cache_r, cache_w      request address and load/store strobes
//   cache_data_in, wmask        store data and byte enables
//   cache_data, cache_ready     load data and completion
//   cache_err                   illegal request combination
//   mem_*                       128-bit line port (write-back / refill)
//   op                          one-hot CACHE maintenance op
//   Tag_Lo/Tag_Hi               tag source for index store tag
//   Tag_Lo_in/Tag_Hi_in         tag result for index load tag
//   cache_tag_w                 Tag_Lo_in write strobe
module dcache_2way (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  addr,
    input  logic         cache_r,
    input  logic         cache_w,
    input  logic [31:0]  cache_data_in,
    input  logic [3:0]   wmask,
    output logic [31:0]  cache_data,
    output logic         cache_ready,
    output logic         cache_err,
    input  logic         mem_ready,
    input  logic [127:0] mem_data,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_data_out,
    output logic         mem_r,
    output logic         mem_w,
    input  logic [6:0]   op,
    input  logic [31:0]  Tag_Lo,
    input  logic [31:0]  Tag_Hi,
    output logic [31:0]  Tag_Lo_in,
    output logic [31:0]  Tag_Hi_in,
    output logic         cache_tag_w
);

    localparam int unsigned SETS   = 256;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned TAG_W  = 20;
    localparam int unsigned LINE_W = 128;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    // Line storage
    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   lru_q;
    logic [LINE_W-1:0] data_q  [2][SETS];

    // Control registers
    state_t state_q, state_d;
    logic   way_q, way_d;
    logic   wb_inv_q, wb_inv_d;
    logic   wb_miss_q, wb_miss_d;

    // Decode
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       word;
    logic             hit0, hit1, hit, hway, vict, vict_dirty;
    logic             is_op, req, multi_op, err;
    logic             op_way, op_act, op_inv, op_wb, tw_valid, tw_dirty;

    // Array write ports
    logic              meta_we, meta_way, meta_valid, meta_dirty;
    logic [TAG_W-1:0]  meta_tag;
    logic              data_we, data_way;
    logic [LINE_W-1:0] data_wval;
    logic              lru_we, lru_val;
    logic [LINE_W-1:0] hit_line, merged;
    logic [6:0]        bpos;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], Tag_Hi, Tag_Lo[31:22]};
    assign Tag_Hi_in   = '0;

    // Address split, hit detection, victim choice and op qualification
    always_comb begin : decode_c
        req_tag    = addr[31:12];
        idx        = addr[11:4];
        word       = addr[3:2];
        hit0       = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
        hit1       = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
        hit        = hit0 || hit1;
        hway       = !hit0;
        if (!valid_q[0][idx])      vict = 1'b0;
        else if (!valid_q[1][idx]) vict = 1'b1;
        else                       vict = lru_q[idx];
        vict_dirty = valid_q[vict][idx] && dirty_q[vict][idx];
        is_op      = |op;
        req        = cache_r || cache_w;
        multi_op   = |(op & (op - 7'd1));
        err        = (cache_r && cache_w) || multi_op || (is_op && req);
        // Hit ops target the hitting way; index ops take the way from addr[12]
        op_way     = (|op[6:4]) ? hway : addr[12];
        op_act     = (|op[6:4]) ? hit : 1'b1;
        tw_valid   = valid_q[op_way][idx];
        tw_dirty   = dirty_q[op_way][idx];
        op_inv     = op[0] || op[3] || op[4] || op[5];
        op_wb      = (op[3] || op[5] || op[6]) && op_act && tw_valid && tw_dirty;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q   <= S_IDLE;
            way_q     <= 1'b0;
            wb_inv_q  <= 1'b0;
            wb_miss_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            way_q     <= way_d;
            wb_inv_q  <= wb_inv_d;
            wb_miss_q <= wb_miss_d;
        end
    end

    // Next-state logic
    always_comb begin : next_state_c
        state_d   = state_q;
        way_d     = way_q;
        wb_inv_d  = wb_inv_q;
        wb_miss_d = wb_miss_q;
        case (state_q)
            S_IDLE: begin
                if (!err) begin
                    if (is_op && op_wb) begin
                        state_d   = S_WB;
                        way_d     = op_way;
                        wb_inv_d  = op_inv;
                        wb_miss_d = 1'b0;
                    end else if (req && !hit) begin
                        way_d     = vict;
                        wb_inv_d  = 1'b0;
                        wb_miss_d = 1'b1;
                        state_d   = vict_dirty ? S_WB : S_REFILL;
                    end
                end
            end
            S_WB: begin
                if (mem_ready) state_d = wb_miss_q ? S_REFILL : S_IDLE;
            end
            S_REFILL: begin
                if (mem_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and array write controls
    always_comb begin : output_c
        cache_data   = '0;
        cache_ready  = 1'b0;
        cache_err    = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        mem_r        = 1'b0;
        mem_w        = 1'b0;
        Tag_Lo_in    = '0;
        cache_tag_w  = 1'b0;
        meta_we      = 1'b0;
        meta_way     = way_q;
        meta_tag     = tag_q[way_q][idx];
        meta_valid   = 1'b0;
        meta_dirty   = 1'b0;
        data_we      = 1'b0;
        data_way     = way_q;
        data_wval    = mem_data;
        lru_we       = 1'b0;
        lru_val      = 1'b0;
        hit_line     = data_q[hway][idx];
        merged       = hit_line;
        bpos         = '0;
        for (int b = 0; b < 4; b++) begin
            bpos = {word, 2'(b), 3'b000};
            if (wmask[b]) merged[bpos +: 8] = cache_data_in[8*b +: 8];
        end
        case (state_q)
            S_IDLE: begin
                if (err) begin
                    cache_err = 1'b1;
                end else if (is_op) begin
                    meta_way    = op_way;
                    meta_tag    = tag_q[op_way][idx];
                    cache_ready = !op_wb;
                    if (op[1]) begin
                        cache_tag_w = 1'b1;
                        Tag_Lo_in   = {10'b0, tw_dirty, tw_valid, tag_q[op_way][idx]};
                    end
                    if (op[2]) begin
                        meta_we    = 1'b1;
                        meta_tag   = Tag_Lo[19:0];
                        meta_valid = Tag_Lo[20];
                        meta_dirty = Tag_Lo[21];
                    end
                    // Invalidating ops with nothing to write back finish here
                    if (op_inv && op_act && !op_wb) meta_we = 1'b1;
                end else if (req && hit) begin
                    cache_ready = 1'b1;
                    lru_we      = 1'b1;
                    lru_val     = !hway;
                    if (cache_r) cache_data = hit_line[{word, 5'b0} +: 32];
                    if (cache_w) begin
                        data_we    = 1'b1;
                        data_way   = hway;
                        data_wval  = merged;
                        meta_we    = 1'b1;
                        meta_way   = hway;
                        meta_tag   = req_tag;
                        meta_valid = 1'b1;
                        meta_dirty = 1'b1;
                    end
                end
            end
            S_WB: begin
                mem_w        = 1'b1;
                mem_addr     = {tag_q[way_q][idx], idx, 4'b0};
                mem_data_out = data_q[way_q][idx];
                if (mem_ready) begin
                    meta_we     = 1'b1;
                    meta_valid  = valid_q[way_q][idx] && !wb_inv_q;
                    meta_dirty  = 1'b0;
                    cache_ready = !wb_miss_q;
                end
            end
            S_REFILL: begin
                mem_r    = 1'b1;
                mem_addr = {addr[31:4], 4'b0};
                if (mem_ready) begin
                    data_we    = 1'b1;
                    meta_we    = 1'b1;
                    meta_tag   = req_tag;
                    meta_valid = 1'b1;
                    meta_dirty = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Tag / valid / dirty / LRU arrays
    always_ff @(posedge clk or negedge rst_n) begin : meta_regs
        if (!rst_n) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[0][s] <= '0;
                tag_q[1][s] <= '0;
            end
        end else begin
            if (meta_we) begin
                tag_q[meta_way][idx]   <= meta_tag;
                valid_q[meta_way][idx] <= meta_valid;
                dirty_q[meta_way][idx] <= meta_dirty;
            end
            if (lru_we) lru_q[idx] <= lru_val;
        end
    end

    // Line data array; contents are only observable behind a valid bit
    always_ff @(posedge clk) begin : data_regs
        if (data_we) data_q[data_way][idx] <= data_wval;
    end

endmodule

// File: tb/tb_dcache_2way.sv
module tb_dcache_2way;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr;
    logic         cache_r, cache_w;
    logic [31:0]  cache_data_in;
    logic [3:0]   wmask;
    logic [31:0]  cache_data;
    logic         cache_ready, cache_err;
    logic         mem_ready;
    logic [127:0] mem_data;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data_out;
    logic         mem_r, mem_w;
    logic [6:0]   op;
    logic [31:0]  Tag_Lo, Tag_Hi, Tag_Lo_in, Tag_Hi_in;
    logic         cache_tag_w;

    dcache_2way dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .cache_r(cache_r), .cache_w(cache_w),
        .cache_data_in(cache_data_in), .wmask(wmask), .cache_data(cache_data),
        .cache_ready(cache_ready), .cache_err(cache_err), .mem_ready(mem_ready),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_r(mem_r), .mem_w(mem_w), .op(op), .Tag_Lo(Tag_Lo), .Tag_Hi(Tag_Hi),
        .Tag_Lo_in(Tag_Lo_in), .Tag_Hi_in(Tag_Hi_in), .cache_tag_w(cache_tag_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat_max = 0;
    logic [31:0] cur_addr;

    // Backing memory, lazily filled with random lines
    logic [127:0] mem [logic [27:0]];

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
        return mem[la];
    endfunction

    // Reference model: per-set lines, LRU by last-use timestamps
    logic [19:0]  m_tag [256][2];
    logic         m_v   [256][2];
    logic         m_d   [256][2];
    logic [127:0] m_dat [256][2];
    int           m_ts  [256][2];
    int           tick;

    logic         e_err, e_wb, e_rf, e_tagw;
    logic [31:0]  e_wb_a, e_rf_a, e_data, e_tl;
    logic [127:0] e_wb_d;

    logic         o_err, o_rdy, o_done;
    logic [31:0]  o_rdat, o_wb_a, o_rf_a, o_tl;
    logic [127:0] o_wb_d;
    int           o_rcyc, o_wb_n, o_rf_n, o_tagw_n;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s addr=0x%08h: observed 0x%0h expected 0x%0h", tag, cur_addr, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 256; s++)
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w] = '0; m_v[s][w] = 1'b0; m_d[s][w] = 1'b0;
                m_dat[s][w] = '0; m_ts[s][w] = 0;
            end
        tick = 0;
    endtask

    task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m,
                              input logic [6:0] o, input logic [31:0] tl);
        int s, h, wd, iw, v, ob;
        logic [19:0]  tg;
        logic [127:0] ln;
        e_wb = 0; e_rf = 0; e_tagw = 0; e_data = '0; e_tl = '0;
        e_wb_a = '0; e_wb_d = '0; e_rf_a = '0;
        e_err = (r && w) || ($countones(o) > 1) || ((o != 0) && (r || w));
        if (e_err) return;
        s = int'(a[11:4]); tg = a[31:12]; wd = int'(a[3:2]); iw = int'(a[12]);
        h = -1;
        for (int i = 0; i < 2; i++) if (m_v[s][i] && m_tag[s][i] == tg) h = i;
        if (o == 0) begin
            if (h < 0) begin
                if (!m_v[s][0])      v = 0;
                else if (!m_v[s][1]) v = 1;
                else                 v = (m_ts[s][1] < m_ts[s][0]) ? 1 : 0;
                if (m_v[s][v] && m_d[s][v]) begin
                    e_wb = 1; e_wb_a = {m_tag[s][v], 8'(s), 4'h0}; e_wb_d = m_dat[s][v];
                end
                e_rf = 1; e_rf_a = {a[31:4], 4'h0};
                m_dat[s][v] = mem_line(a[31:4]);
                m_tag[s][v] = tg; m_v[s][v] = 1; m_d[s][v] = 0;
                h = v;
            end
            ln = m_dat[s][h];
            if (r) e_data = ln[32*wd +: 32];
            if (w) begin
                for (int b = 0; b < 4; b++) if (m[b]) ln[32*wd + 8*b +: 8] = d[8*b +: 8];
                m_dat[s][h] = ln; m_d[s][h] = 1;
            end
            tick++; m_ts[s][h] = tick;
        end else begin
            ob = 0;
            for (int i = 0; i < 7; i++) if (o[i]) ob = i;
            case (ob)
                0: begin m_v[s][iw] = 0; m_d[s][iw] = 0; end
                1: begin e_tagw = 1; e_tl = {10'b0, m_d[s][iw], m_v[s][iw], m_tag[s][iw]}; end
                2: begin m_tag[s][iw] = tl[19:0]; m_v[s][iw] = tl[20]; m_d[s][iw] = tl[21]; end
                3: begin
                    if (m_v[s][iw] && m_d[s][iw]) begin
                        e_wb = 1; e_wb_a = {m_tag[s][iw], 8'(s), 4'h0}; e_wb_d = m_dat[s][iw];
                    end
                    m_v[s][iw] = 0; m_d[s][iw] = 0;
                end
                4: if (h >= 0) begin m_v[s][h] = 0; m_d[s][h] = 0; end
                5: if (h >= 0) begin
                    if (m_d[s][h]) begin
                        e_wb = 1; e_wb_a = {m_tag[s][h], 8'(s), 4'h0}; e_wb_d = m_dat[s][h];
                    end
                    m_v[s][h] = 0; m_d[s][h] = 0;
                end
                default: if (h >= 0 && m_d[s][h]) begin
                    e_wb = 1; e_wb_a = {m_tag[s][h], 8'(s), 4'h0}; e_wb_d = m_dat[s][h];
                    m_d[s][h] = 0;
                end
            endcase
        end
    endtask

    // Issue one request/op (called just after a rising edge), act as memory, compare with model
    task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m,
                           input logic [6:0] o, input logic [31:0] tl);
        int wait_cnt, cyc;
        cur_addr = a;
        model_step(r, w, a, d, m, o, tl);
        addr = a; cache_r = r; cache_w = w; cache_data_in = d; wmask = m; op = o; Tag_Lo = tl;
        o_err = 0; o_rdy = 0; o_done = 0; o_rdat = '0; o_rcyc = -1;
        o_wb_n = 0; o_rf_n = 0; o_tagw_n = 0; o_wb_a = '0; o_wb_d = '0; o_rf_a = '0; o_tl = '0;
        wait_cnt = $urandom_range(lat_max, 0);
        cyc = 0;
        while (!o_done && cyc < 64) begin
            @(negedge clk);
            if (cache_tag_w) begin o_tagw_n++; o_tl = Tag_Lo_in; end
            if (cache_err) begin
                o_err = 1; o_done = 1;
            end else if (cache_ready) begin
                o_rdy = 1; o_rdat = cache_data; o_rcyc = cyc; o_done = 1;
            end else if (mem_w || mem_r) begin
                if (wait_cnt > 0) wait_cnt--;
                else begin
                    mem_ready = 1'b1;
                    if (mem_w) begin
                        o_wb_n++; o_wb_a = mem_addr; o_wb_d = mem_data_out;
                        mem[mem_addr[31:4]] = mem_data_out;
                    end else begin
                        o_rf_n++; o_rf_a = mem_addr; mem_data = mem_line(mem_addr[31:4]);
                    end
                    wait_cnt = $urandom_range(lat_max, 0);
                    #1;
                    if (cache_ready) begin o_rdy = 1; o_rdat = cache_data; o_rcyc = cyc; o_done = 1; end
                end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            cyc++;
        end
        cache_r = 0; cache_w = 0; op = '0;
        chk("done", o_done, 1'b1);
        chk("err", o_err, e_err);
        chk("ready", o_rdy, !e_err);
        chk("wb_count", 128'(o_wb_n), 128'(e_wb));
        if (e_wb) begin
            chk("wb_addr", o_wb_a, e_wb_a);
            chk("wb_data", o_wb_d, e_wb_d);
        end
        chk("refill_count", 128'(o_rf_n), 128'(e_rf));
        if (e_rf) chk("refill_addr", o_rf_a, e_rf_a);
        if (r && !e_err) chk("load_data", o_rdat, e_data);
        chk("tag_w_count", 128'(o_tagw_n), 128'(e_tagw));
        if (e_tagw) chk("tag_lo_in", o_tl, e_tl);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    logic [19:0] tpool [4];
    logic [7:0]  spool [2];

    initial begin
        rst_n = 1'b0; addr = '0; cache_r = 0; cache_w = 0; cache_data_in = '0; wmask = '0;
        mem_ready = 0; mem_data = '0; op = '0; Tag_Lo = '0; Tag_Hi = '0;
        model_reset();
        #1;
        chk("rst_ready", cache_ready, 1'b0);
        chk("rst_mem_r", mem_r, 1'b0);
        chk("rst_mem_w", mem_w, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {cache_ready, cache_err, mem_r, mem_w, cache_tag_w, mem_addr, Tag_Lo_in, Tag_Hi_in, cache_data},
            '0);
        @(posedge clk); #1;

        // Index store tag then index load tag on way0 set 0xFF
        run_req(0, 0, 32'h0000_0FF0, '0, '0, 7'b000_0100, 32'h001F_FFFF);
        run_req(0, 0, 32'h0000_0FF0, '0, '0, 7'b000_0010, '0);
        chk("dir_tag_lo", o_tl, 32'h001F_FFFF);
        chk("dir_tag_w_once", 128'(o_tagw_n), 128'd1);
        apply_reset();

        // Cold load: refill address, word 0 and latency
        mem[28'hFFF_FFFF] = 128'h11111111_22222222_33333333_44444444;
        run_req(1, 0, 32'hFFFF_FFF0, '0, '0, '0, '0);
        chk("dir_cold_data", o_rdat, 32'h4444_4444);
        chk("dir_cold_addr", o_rf_a, 32'hFFFF_FFF0);
        chk("dir_cold_latency", 128'(o_rcyc), 128'd2);

        // Fill way1, dirty it, then a clean LRU victim (way0) is replaced
        run_req(1, 0, 32'hA5A5_AFF0, '0, '0, '0, '0);
        run_req(0, 1, 32'hA5A5_AFF4, 32'hAAAA_AAAA, 4'hF, '0, '0);
        chk("dir_store_hit_nomem", 128'(o_rf_n + o_wb_n), 128'd0);
        run_req(1, 0, 32'h5A5A_5FF0, '0, '0, '0, '0);
        chk("dir_clean_victim_wb", 128'(o_wb_n), 128'd0);
        chk("dir_clean_victim_rf", 128'(o_rf_n), 128'd1);

        // Dirty LRU victim: write-back then refill
        run_req(0, 1, 32'hFFFF_FFFC, 32'h1234_5678, 4'b0101, '0, '0);
        chk("dir_dirty_wb_addr", o_wb_a, 32'hA5A5_AFF0);
        chk("dir_dirty_wb_word1", 128'(o_wb_d[63:32]), 128'h0AAAA_AAAA);
        chk("dir_dirty_rf", 128'(o_rf_n), 128'd1);

        // Hit write-back twice, hit invalidate then reload misses
        run_req(0, 0, 32'hFFFF_FFF0, '0, '0, 7'b100_0000, '0);
        chk("dir_hitwb_one", 128'(o_wb_n), 128'd1);
        run_req(0, 0, 32'hFFFF_FFF0, '0, '0, 7'b100_0000, '0);
        chk("dir_hitwb_clean", 128'(o_wb_n), 128'd0);
        chk("dir_hitwb_fast", 128'(o_rcyc), 128'd0);
        run_req(0, 0, 32'hFFFF_FFF0, '0, '0, 7'b001_0000, '0);
        run_req(1, 0, 32'hFFFF_FFF0, '0, '0, '0, '0);
        chk("dir_inv_reload", 128'(o_rf_n), 128'd1);

        // Illegal combination: error only, state unchanged
        run_req(1, 1, 32'h5A5A_5FF0, 32'hDEAD_BEEF, 4'hF, '0, '0);
        chk("dir_err", o_err, 1'b1);
        run_req(1, 0, 32'h5A5A_5FF0, '0, '0, '0, '0);
        chk("dir_err_nochange", 128'(o_rf_n), 128'd0);

        // Reset in the middle of a refill drops the memory request
        begin
            int n;
            addr = 32'h1234_5000; cache_r = 1; n = 0;
            while (!mem_r && n < 10) begin @(negedge clk); n++; end
            chk("rst_mid_setup", mem_r, 1'b1);
            rst_n = 1'b0;
            #1;
            chk("rst_mid_mem_r", mem_r, 1'b0);
            chk("rst_mid_mem_w", mem_w, 1'b0);
            chk("rst_mid_ready", cache_ready, 1'b0);
            cache_r = 0;
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            @(posedge clk); #1;
        end

        // Randomised traffic over a small conflict set
        tpool[0] = 20'h12345; tpool[1] = 20'hABCDE; tpool[2] = 20'h00FFF; tpool[3] = 20'h5A5A4;
        spool[0] = 8'h00;     spool[1] = 8'h3C;
        lat_max = 3;
        for (int it = 0; it < 400; it++) begin
            int k;
            logic [31:0] a, tl;
            logic [6:0]  o;
            a = {tpool[$urandom_range(3, 0)], spool[$urandom_range(1, 0)], 2'($urandom_range(3, 0)), 2'b00};
            a[12] = 1'($urandom_range(1, 0));
            k = $urandom_range(99, 0);
            if (k < 40)      run_req(1, 0, a, '0, '0, '0, '0);
            else if (k < 75) run_req(0, 1, a, $urandom, 4'($urandom_range(15, 1)), '0, '0);
            else if (k < 92) begin
                o = 7'(1 << $urandom_range(6, 0));
                tl = $urandom & 32'hFFEF_FFFF;
                run_req(0, 0, a, '0, '0, o, tl);
            end else begin
                k = $urandom_range(2, 0);
                if (k == 0)      run_req(1, 1, a, $urandom, 4'hF, '0, '0);
                else if (k == 1) run_req(0, 0, a, '0, '0, 7'b000_1001, '0);
                else             run_req(1, 0, a, '0, '0, 7'b100_0000, '0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
